// File: rtl/div_ctrl_pkg.sv
// Shared encoding for the divider controller: operand width and the 3-bit FSM states.
package div_ctrl_pkg;

   localparam int unsigned DIV_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEND  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of N independent lanes; used to form
// operand magnitudes and to restore the sign of the quotient and remainder.
module div_sign_fix #(
   parameter int unsigned W = 32,
   parameter int unsigned N = 1
) (
   input  logic [N-1:0][W-1:0] val_i,
   input  logic [N-1:0]        neg_i,
   output logic [N-1:0][W-1:0] val_o
);

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign val_o[i] = neg_i[i] ? -val_i[i] : val_i[i];
   end

endmodule

// File: rtl/div_ctrl.sv
// Sequences one DIV/DIVU through an unsigned AXI-stream divider: sends operand
// magnitudes, sign-fixes the result, and drains in-flight work on cancel.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   input  logic               req_signed,
   input  logic [DIV_W-1:0]   req_src1,
   input  logic [DIV_W-1:0]   req_src2,
   output logic               req_ready,
   input  logic               cancel,
   input  logic               res_ack,
   output logic               res_valid,
   output logic [DIV_W-1:0]   res_quot,
   output logic [DIV_W-1:0]   res_rem,
   output logic               busy,
   output logic               dividend_tvalid,
   input  logic               dividend_tready,
   output logic [DIV_W-1:0]   dividend_tdata,
   output logic               divisor_tvalid,
   input  logic               divisor_tready,
   output logic [DIV_W-1:0]   divisor_tdata,
   input  logic               dout_tvalid,
   input  logic [2*DIV_W-1:0] dout_tdata
);

   state_e                  state_q;
   logic [DIV_W-1:0]        dvd_q, dvs_q, quot_q, rem_q;
   logic                    signed_q, sign_dvd_q, sign_dvs_q;
   logic                    sent_dvd_q, sent_dvs_q, cancel_q;
   logic                    sent_dvd_d, sent_dvs_d, cancel_d;
   logic [1:0][DIV_W-1:0]   op_raw, op_mag;
   logic [1:0]              op_neg;
   logic [DIV_W-1:0]        quot_fix, rem_fix;

   assign op_raw = {req_src1, req_src2};
   assign op_neg = {req_signed & req_src1[DIV_W-1], req_signed & req_src2[DIV_W-1]};

   div_sign_fix #(.W(DIV_W), .N(2)) u_op_fix (
      .val_i (op_raw),
      .neg_i (op_neg),
      .val_o (op_mag)
   );

   div_sign_fix #(.W(DIV_W), .N(1)) u_quot_fix (
      .val_i (dout_tdata[2*DIV_W-1:DIV_W]),
      .neg_i (signed_q & (sign_dvd_q ^ sign_dvs_q)),
      .val_o (quot_fix)
   );

   div_sign_fix #(.W(DIV_W), .N(1)) u_rem_fix (
      .val_i (dout_tdata[DIV_W-1:0]),
      .neg_i (signed_q & sign_dvd_q),
      .val_o (rem_fix)
   );

   // tvalid is a pure function of registered state, so it cannot drop before acceptance.
   assign dividend_tvalid = (state_q == ST_SEND) && !sent_dvd_q;
   assign divisor_tvalid  = (state_q == ST_SEND) && !sent_dvs_q;
   assign dividend_tdata  = dvd_q;
   assign divisor_tdata   = dvs_q;

   assign sent_dvd_d = sent_dvd_q | (dividend_tvalid & dividend_tready);
   assign sent_dvs_d = sent_dvs_q | (divisor_tvalid & divisor_tready);
   assign cancel_d   = cancel_q | cancel;

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign res_valid = (state_q == ST_DONE);
   assign res_quot  = quot_q;
   assign res_rem   = rem_q;

   // NOTE: every register here uses <= so all updates commit together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         dvd_q      <= '0;
         dvs_q      <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         signed_q   <= 1'b0;
         sign_dvd_q <= 1'b0;
         sign_dvs_q <= 1'b0;
         sent_dvd_q <= 1'b0;
         sent_dvs_q <= 1'b0;
         cancel_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid && !cancel) begin
                  dvd_q      <= op_mag[1];
                  dvs_q      <= op_mag[0];
                  signed_q   <= req_signed;
                  sign_dvd_q <= req_src1[DIV_W-1];
                  sign_dvs_q <= req_src2[DIV_W-1];
                  sent_dvd_q <= 1'b0;
                  sent_dvs_q <= 1'b0;
                  cancel_q   <= 1'b0;
                  state_q    <= ST_SEND;
               end
            end
            ST_SEND: begin
               sent_dvd_q <= sent_dvd_d;
               sent_dvs_q <= sent_dvs_d;
               cancel_q   <= cancel_d;
               if (sent_dvd_d && sent_dvs_d) begin
                  state_q <= cancel_d ? ST_DRAIN : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cancel) begin
                  // A result arriving with the cancel is simply dropped; nothing is left in flight.
                  state_q <= dout_tvalid ? ST_IDLE : ST_DRAIN;
               end else if (dout_tvalid) begin
                  quot_q  <= quot_fix;
                  rem_q   <= rem_fix;
                  state_q <= ST_DONE;
               end
            end
            ST_DRAIN: begin
               if (dout_tvalid) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_DONE: begin
               if (res_ack || cancel) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
